// File: rtl/codec_intf_if.sv
// Signal bundle between codec_intf, the equalizer datapath and the CS4272 pins.
// The slave modport is the bridge itself; master is the datapath/CODEC side.
interface codec_intf_if;
  logic [15:0] lft_out;
  logic [15:0] rht_out;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        valid;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDout;
  logic        SDin;
  logic        RSTn;

  modport slave (
    input  lft_out, rht_out, SDout,
    output lft_in, rht_in, valid, MCLK, SCLK, LRCLK, SDin, RSTn
  );

  modport master (
    output lft_out, rht_out, SDout,
    input  lft_in, rht_in, valid, MCLK, SCLK, LRCLK, SDin, RSTn
  );
endinterface

// File: rtl/codec_intf.sv
// CS4272 left-justified serial bridge: derives MCLK/SCLK/LRCLK from one 10-bit
// frame counter, deserializes SDout into stereo pairs and serializes SDin.
module codec_intf (
  input  logic        clk,
  input  logic        rst_n,
  codec_intf_if.slave bus
);
  logic [9:0]  r_cnt;
  logic        r_lrclk;
  logic        r_rstn;
  logic        r_valid;
  logic [15:0] r_rx_shift;
  logic [15:0] r_tx_shift;
  logic [15:0] r_lft_in;
  logic [15:0] r_rht_in;

  logic [9:0]  w_cnt_next;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic [15:0] w_rx_word;

  assign w_cnt_next  = r_cnt + 10'd1;
  assign w_sclk_rise = (r_cnt[4:0] == 5'h0F);
  assign w_sclk_fall = (r_cnt[4:0] == 5'h1F);
  assign w_rx_word   = {r_rx_shift[14:0], bus.SDout};

  // LRCLK gets its own flop so the inverted counter MSB never passes through logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 10'd0;
      r_lrclk    <= 1'b1;
      r_rstn     <= 1'b0;
      r_valid    <= 1'b0;
      r_rx_shift <= 16'd0;
      r_tx_shift <= 16'd0;
      r_lft_in   <= 16'd0;
      r_rht_in   <= 16'd0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_lrclk <= ~w_cnt_next[9];
      if (r_cnt == 10'h3FF)
        r_rstn <= 1'b1;

      if (w_sclk_rise)
        r_rx_shift <= w_rx_word;
      if (r_cnt == 10'h1EF)
        r_lft_in <= w_rx_word;
      if (r_cnt == 10'h3EF)
        r_rht_in <= w_rx_word;
      r_valid <= (r_cnt == 10'h3EF) && r_rstn;

      // Half-frame loads land on an SCLK fall, so they must win over the shift.
      if (r_cnt == 10'h3FF)
        r_tx_shift <= bus.lft_out;
      else if (r_cnt == 10'h1FF)
        r_tx_shift <= bus.rht_out;
      else if (w_sclk_fall)
        r_tx_shift <= {r_tx_shift[14:0], 1'b0};
    end
  end

  assign bus.MCLK   = r_cnt[1];
  assign bus.SCLK   = r_cnt[4];
  assign bus.LRCLK  = r_lrclk;
  assign bus.RSTn   = r_rstn;
  assign bus.valid  = r_valid;
  assign bus.lft_in = r_lft_in;
  assign bus.rht_in = r_rht_in;
  assign bus.SDin   = r_tx_shift[15];
endmodule
